// File: rtl/note_sequencer.sv
// Song walker for one voice: fetches {note, duration} entries from a synchronous
// song ROM, counts each entry's duration in beats and strobes notes into the player.
module note_sequencer #(
  parameter int IDX_BITS  = 5,
  parameter int SONG_BITS = 2,
  parameter int DUR_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song_sel,
  input  logic                          beat,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [6+DUR_BITS-1:0]         rom_data,
  output logic [5:0]                    note_to_load,
  output logic                          load_new_note,
  output logic                          note_done,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [DUR_BITS-1:0] DUR_ONE = DUR_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

  state_t                 state;
  logic [IDX_BITS-1:0]    index;
  logic [SONG_BITS-1:0]   song_q;
  logic [DUR_BITS-1:0]    dur_cnt;

  logic [5:0]             rom_note;
  logic [DUR_BITS-1:0]    rom_dur;
  logic                   song_change;
  logic                   last_entry;

  assign rom_note    = rom_data[DUR_BITS +: 6];
  assign rom_dur     = rom_data[DUR_BITS-1:0];
  assign song_change = (song_sel != song_q);
  assign last_entry  = &index;
  assign rom_addr    = {song_q, index};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      index         <= '0;
      song_q        <= '0;
      dur_cnt       <= '0;
      note_to_load  <= '0;
      load_new_note <= 1'b0;
      note_done     <= 1'b1;
      song_done     <= 1'b0;
    end else begin
      load_new_note <= 1'b0;
      // A new song selection aborts whatever is in flight, including a pending beat.
      if (state != S_IDLE && song_change) begin
        state     <= S_IDLE;
        index     <= '0;
        note_done <= 1'b1;
        song_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play) begin
              song_q <= song_sel;
              index  <= '0;
              state  <= S_FETCH;
            end
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            if (rom_dur == '0) begin
              state     <= S_DONE;
              song_done <= 1'b1;
              note_done <= 1'b1;
            end else begin
              dur_cnt <= rom_dur;
              state   <= S_LOAD;
              // Rests keep the previous note code and stay silent.
              if (rom_note != 6'd0) begin
                note_to_load  <= rom_note;
                load_new_note <= 1'b1;
                note_done     <= 1'b0;
              end else begin
                note_done <= 1'b1;
              end
            end
          end
          S_LOAD: state <= S_PLAY;
          S_PLAY: begin
            if (beat && play) begin
              dur_cnt <= dur_cnt - DUR_ONE;
              if (dur_cnt == DUR_ONE) begin
                note_done <= 1'b1;
                if (last_entry) begin
                  state     <= S_DONE;
                  song_done <= 1'b1;
                end else begin
                  index <= index + IDX_ONE;
                  state <= S_FETCH;
                end
              end
            end
          end
          S_DONE: begin
            if (!play) begin
              state     <= S_IDLE;
              index     <= '0;
              song_done <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
